// File: rtl/n_term_dsp_loopback.sv
// North-edge terminator: index-reversing loopback of northbound wires onto southbound
// wires, with per-class optional pipeline stage, park, serial config and activity counter.
module n_term_dsp_loopback #(
  parameter int CNT_W = 16
) (
  input  logic             UserCLK,
  input  logic             RESETn,
  input  logic [3:0]       N1END,
  input  logic [7:0]       N2MID,
  input  logic [7:0]       N2END,
  input  logic [15:0]      N4END,
  input  logic [15:0]      NN4END,
  output logic [3:0]       S1BEG,
  output logic [7:0]       S2BEG,
  output logic [7:0]       S2BEGb,
  output logic [15:0]      S4BEG,
  output logic [15:0]      SS4BEG,
  input  logic             CfgIn,
  input  logic             CfgShift,
  input  logic             CfgLoad,
  output logic             CfgOut,
  output logic [CNT_W-1:0] ActCnt,
  input  logic             ActClr
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [7:0]       r_shadow;
  logic [7:0]       r_active;
  logic [3:0]       w_s1_map,  r_s1_pipe;
  logic [7:0]       w_s2_map,  r_s2_pipe;
  logic [7:0]       w_s2b_map, r_s2b_pipe;
  logic [15:0]      w_s4_map,  r_s4_pipe;
  logic [15:0]      w_ss4_map, r_ss4_pipe;
  logic [51:0]      w_in;
  logic [51:0]      r_prev;
  logic             r_valid;
  logic             w_activity;
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused_rsvd;

  // Reserved config bits are stored only; they steer nothing.
  assign w_unused_rsvd = ^r_active[7:6];

  // Index reversal of every wire class.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_s1_map[i] = N1END[3-i];
    end
    for (int i = 0; i < 8; i++) begin
      w_s2_map[i]  = N2MID[7-i];
      w_s2b_map[i] = N2END[7-i];
    end
    for (int i = 0; i < 16; i++) begin
      w_s4_map[i]  = N4END[15-i];
      w_ss4_map[i] = NN4END[15-i];
    end
  end

  // Output select: park overrides, otherwise registered or direct path per class.
  always_comb begin
    if (r_active[5]) begin
      S1BEG  = 4'h0;
      S2BEG  = 8'h00;
      S2BEGb = 8'h00;
      S4BEG  = 16'h0000;
      SS4BEG = 16'h0000;
    end else begin
      S1BEG  = r_active[0] ? r_s1_pipe  : w_s1_map;
      S2BEG  = r_active[1] ? r_s2_pipe  : w_s2_map;
      S2BEGb = r_active[2] ? r_s2b_pipe : w_s2b_map;
      S4BEG  = r_active[3] ? r_s4_pipe  : w_s4_map;
      SS4BEG = r_active[4] ? r_ss4_pipe : w_ss4_map;
    end
  end

  // Pipeline stages run unconditionally so enabling one never exposes stale data.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s1_pipe  <= 4'h0;
      r_s2_pipe  <= 8'h00;
      r_s2b_pipe <= 8'h00;
      r_s4_pipe  <= 16'h0000;
      r_ss4_pipe <= 16'h0000;
    end else begin
      r_s1_pipe  <= w_s1_map;
      r_s2_pipe  <= w_s2_map;
      r_s2b_pipe <= w_s2b_map;
      r_s4_pipe  <= w_s4_map;
      r_ss4_pipe <= w_ss4_map;
    end
  end

  // Serial config chain; a simultaneous load takes the pre-shift shadow value.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_shadow <= 8'h00;
      r_active <= 8'h00;
    end else begin
      if (CfgShift) begin
        r_shadow <= {r_shadow[6:0], CfgIn};
      end
      if (CfgLoad) begin
        r_active <= r_shadow;
      end
    end
  end

  assign CfgOut = r_shadow[7];

  assign w_in       = {NN4END, N4END, N2END, N2MID, N1END};
  assign w_activity = r_valid && (w_in != r_prev);

  // Previous-sample register; valid only once it holds a real post-reset sample.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_prev  <= 52'h0;
      r_valid <= 1'b0;
    end else begin
      r_prev  <= w_in;
      r_valid <= 1'b1;
    end
  end

  // Saturating activity counter, clear has priority.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt <= CNT_ZERO;
    end else if (ActClr) begin
      r_cnt <= CNT_ZERO;
    end else if (w_activity && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign ActCnt = r_cnt;

endmodule

// File: doc/n_term_dsp_loopback.md
N_TERM_DSP_LOOPBACK -- requirements
Module: n_term_dsp_loopback

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the activity counter.
REQ-002 SHALL have port UserCLK  in  1  single block clock, rising edge.
REQ-003 SHALL have port RESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port N1END  in  4  northbound single wires arriving at north edge.
REQ-005 SHALL have port N2MID  in  8  northbound double wires, mid tap.
REQ-006 SHALL have port N2END  in  8  northbound double wires, end tap.
REQ-007 SHALL have port N4END  in  16  northbound quad wires.
REQ-008 SHALL have port NN4END  in  16  northbound long-quad wires.
REQ-009 SHALL have port S1BEG  out  4  southbound single wires driven back into the column.
REQ-010 SHALL have port S2BEG  out  8  southbound double wires.
REQ-011 SHALL have port S2BEGb  out  8  southbound double wires, second segment.
REQ-012 SHALL have port S4BEG  out  16  southbound quad wires.
REQ-013 SHALL have port SS4BEG  out  16  southbound long-quad wires.
REQ-014 SHALL have port CfgIn  in  1  serial config data.
REQ-015 SHALL have port CfgShift  in  1  shift CfgIn into shadow register this cycle.
REQ-016 SHALL have port CfgLoad  in  1  copy shadow to active config this cycle.
REQ-017 SHALL have port CfgOut  out  1  serial config out (shadow[7]), for daisy-chaining.
REQ-018 SHALL have port ActCnt  out  CNT_W  saturating count of cycles with input activity.
REQ-019 SHALL have port ActClr  in  1  synchronous clear of ActCnt.

Function
REQ-020 SHALL map loopback with index reversal: S1BEG[i]<-N1END[3-i]; S2BEG[i]<-N2MID[7-i]; S2BEGb[i]<-N2END[7-i]; S4BEG[i]<-N4END[15-i]; SS4BEG[i]<-NN4END[15-i].
REQ-021 SHALL hold an 8-bit shadow register: CfgShift=1 -> shadow <= {shadow[6:0], CfgIn}.
REQ-022 SHALL copy shadow to 8-bit active config when CfgLoad=1; CfgLoad and CfgShift both 1 -> active gets pre-shift shadow value, shadow shifts.
REQ-023 SHALL define active[0..4] = register-enable for classes S1, S2, S2b, S4, SS4 respectively; active[5] = park; active[7:6] reserved, stored, no effect.
REQ-024 SHALL, for class with register-enable=0, drive output combinationally from input (zero latency).
REQ-025 SHALL, for class with register-enable=1, drive output from a per-class pipeline register capturing mapped input each cycle (one-cycle latency).
REQ-026 SHALL keep pipeline registers clocking regardless of enable, so toggling enable takes effect next output evaluation with no stale data older than one cycle.
REQ-027 SHALL, when park=1, force all 52 outputs to 0 combinationally, overriding REQ-024/025.
REQ-028 SHALL register all 52 inputs into a previous-sample register every cycle.
REQ-029 SHALL increment ActCnt by 1 in any cycle where current inputs differ from previous sample in any bit.
REQ-030 SHALL saturate ActCnt at 2^CNT_W-1 (no wrap).
REQ-031 SHALL give ActClr priority over increment: ActClr=1 -> ActCnt=0 next cycle.
REQ-032 SHALL exclude the first cycle after reset release from activity counting (previous-sample register not yet valid).

Reset
REQ-033 SHALL, on RESETn=0, asynchronously clear shadow, active config, pipeline registers, previous-sample register, valid flag, ActCnt to 0.
REQ-034 SHALL, after reset, operate in combinational unparked loopback (all enables 0, park 0); CfgOut=0.
REQ-035 SHALL abort any partial config shift on reset mid-sequence; shadow contents discarded.

Verification
VER-001 Reset, N4END=16'h0001 -> S4BEG=16'h8000 same cycle; N1END=4'b0011 -> S1BEG=4'b1100.
VER-002 Shift 8'h08 MSB-first, pulse CfgLoad; N4END 16'h0000->16'h00F0 -> S4BEG=16'h0F00 one cycle later, S1BEG still combinational.
VER-003 Load 8'h20 (park) -> all outputs 0 regardless of inputs; load 8'h00 -> loopback resumes same cycle.
VER-004 Toggle NN4END[0] every cycle for 10 cycles after reset -> ActCnt=10; hold inputs static 5 cycles -> ActCnt unchanged.
VER-005 CNT_W=4, continuous toggling 20 cycles -> ActCnt=15 held; ActClr with toggling same cycle -> ActCnt=0 next cycle.
VER-006 Assert RESETn=0 after 4 of 8 shift bits and with registered mode active -> outputs immediately combinational, ActCnt=0, CfgOut=0.
